// File: rtl/dsp48a1_pkg.sv
// Shared definitions for the DSP48A1 slice model: opmode bit positions,
// X/Z operand select encodings and default datapath widths.
package dsp48a1_pkg;

    localparam int P_WIDTH_DEF = 48;
    localparam int M_WIDTH_DEF = 36;

    localparam int OP_POSTSUB = 7;
    localparam int OP_CIN     = 5;
    localparam int OP_Z_HI    = 3;
    localparam int OP_Z_LO    = 2;
    localparam int OP_X_HI    = 1;
    localparam int OP_X_LO    = 0;

    typedef enum logic [1:0] {
        X_ZERO = 2'b00,
        X_M    = 2'b01,
        X_P    = 2'b10,
        X_DAB  = 2'b11
    } x_sel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'b00,
        Z_PCIN = 2'b01,
        Z_P    = 2'b10,
        Z_C    = 2'b11
    } z_sel_e;

endpackage

// File: rtl/param_reg_2x1mux.sv
// Optional pipeline register: SEL=1 gives a clock-enabled register with
// sync or async active-high reset, SEL=0 passes d straight through.
module param_reg_2x1mux #(
    parameter int    WIDTH   = 1,
    parameter string RSTTYPE = "ASYNC",
    parameter int    SEL     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Control inputs are legitimately idle when the stage is bypassed.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, ce};

    generate
        if (SEL == 0) begin : g_bypass
            assign q = d;
        end else begin : g_reg
            logic [WIDTH-1:0] q_r;

            if (RSTTYPE == "SYNC") begin : g_sync
                always_ff @(posedge clk) begin
                    if (rst)     q_r <= '0;
                    else if (ce) q_r <= d;
                end
            end else begin : g_async
                // NOTE: reset sits in the sensitivity list so it acts without a clock edge and overrides ce.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)     q_r <= '0;
                    else if (ce) q_r <= d;
                end
            end

            assign q = q_r;
        end
    endgenerate

endmodule

// File: rtl/post_add_acc.sv
// DSP48A1 post-adder/subtracter and P accumulator: X/Z operand muxes,
// carry-in selection, 49-bit add/sub and the P/carry-out registers.
module post_add_acc
    import dsp48a1_pkg::*;
#(
    parameter int    P_WIDTH     = P_WIDTH_DEF,
    parameter int    M_WIDTH     = M_WIDTH_DEF,
    parameter int    CREG        = 1,
    parameter int    OPMODEREG   = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYOUTREG = 1,
    parameter string CARRYINSEL  = "OPMODE5"
) (
    input  logic               clk,
    input  logic               rst_c,
    input  logic               rst_opmode,
    input  logic               rst_carryin,
    input  logic               rst_p,
    input  logic               ce_c,
    input  logic               ce_opmode,
    input  logic               ce_carryin,
    input  logic               ce_p,
    input  logic [7:0]         opmode,
    input  logic [M_WIDTH-1:0] m,
    input  logic [P_WIDTH-1:0] dab,
    input  logic [P_WIDTH-1:0] c,
    input  logic [P_WIDTH-1:0] pcin,
    input  logic               carryin,
    output logic [P_WIDTH-1:0] p,
    output logic [P_WIDTH-1:0] pcout,
    output logic               carryout,
    output logic               carryoutf
);

    // Any CARRYINSEL other than "CARRYIN" falls back to opmode[5].
    localparam bit USE_CIN_PORT = (CARRYINSEL == "CARRYIN");

    logic [P_WIDTH-1:0] c_r;
    logic [7:0]         opmode_r;
    logic               cin_sel;
    logic               cyi;
    logic [P_WIDTH-1:0] p_fb;
    logic [P_WIDTH-1:0] x_mux;
    logic [P_WIDTH-1:0] z_mux;
    logic [P_WIDTH:0]   sum_full;

    param_reg_2x1mux #(.WIDTH(P_WIDTH), .RSTTYPE("ASYNC"), .SEL(CREG)) u_creg (
        .clk (clk),
        .rst (rst_c),
        .ce  (ce_c),
        .d   (c),
        .q   (c_r)
    );

    param_reg_2x1mux #(.WIDTH(8), .RSTTYPE("ASYNC"), .SEL(OPMODEREG)) u_opmodereg (
        .clk (clk),
        .rst (rst_opmode),
        .ce  (ce_opmode),
        .d   (opmode),
        .q   (opmode_r)
    );

    assign cin_sel = USE_CIN_PORT ? carryin : opmode_r[OP_CIN];

    param_reg_2x1mux #(.WIDTH(1), .RSTTYPE("ASYNC"), .SEL(CARRYINREG)) u_cyireg (
        .clk (clk),
        .rst (rst_carryin),
        .ce  (ce_carryin),
        .d   (cin_sel),
        .q   (cyi)
    );

    // Feedback is only meaningful from a real P register; without one it is a loop.
    generate
        if (PREG != 0) begin : g_fb_reg
            assign p_fb = p;
        end else begin : g_fb_none
            assign p_fb = '0;
            always_comb begin
                assert (opmode_r[OP_X_HI:OP_X_LO] != X_P && opmode_r[OP_Z_HI:OP_Z_LO] != Z_P)
                    else $error("post_add_acc: P feedback selected with PREG=0 (combinational loop)");
            end
        end
    endgenerate

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        x_mux = '0;
        case (x_sel_e'(opmode_r[OP_X_HI:OP_X_LO]))
            X_ZERO: x_mux = '0;
            X_M:    x_mux = {{(P_WIDTH-M_WIDTH){1'b0}}, m};
            X_P:    x_mux = p_fb;
            X_DAB:  x_mux = dab;
            default: x_mux = '0;
        endcase
    end

    always_comb begin
        z_mux = '0;
        case (z_sel_e'(opmode_r[OP_Z_HI:OP_Z_LO]))
            Z_ZERO: z_mux = '0;
            Z_PCIN: z_mux = pcin;
            Z_P:    z_mux = p_fb;
            Z_C:    z_mux = c_r;
            default: z_mux = '0;
        endcase
    end

    // On subtract, bit 48 of the two's-complement result flags a borrow.
    always_comb begin
        sum_full = '0;
        if (opmode_r[OP_POSTSUB])
            sum_full = {1'b0, z_mux} - ({1'b0, x_mux} + {{P_WIDTH{1'b0}}, cyi});
        else
            sum_full = {1'b0, z_mux} + {1'b0, x_mux} + {{P_WIDTH{1'b0}}, cyi};
    end

    param_reg_2x1mux #(.WIDTH(P_WIDTH), .RSTTYPE("ASYNC"), .SEL(PREG)) u_preg (
        .clk (clk),
        .rst (rst_p),
        .ce  (ce_p),
        .d   (sum_full[P_WIDTH-1:0]),
        .q   (p)
    );

    param_reg_2x1mux #(.WIDTH(1), .RSTTYPE("ASYNC"), .SEL(CARRYOUTREG)) u_cyoreg (
        .clk (clk),
        .rst (rst_p),
        .ce  (ce_p),
        .d   (sum_full[P_WIDTH]),
        .q   (carryout)
    );

    assign pcout     = p;
    assign carryoutf = carryout;

    logic unused_op;
    assign unused_op = ^{opmode_r[6], opmode_r[4]};

endmodule

// File: tb/tb_post_add_acc.sv
// Scoreboard bench for post_add_acc: one fully registered instance and two
// fully combinational instances (opmode[5] and carryin-port carry select).
module tb_post_add_acc;

    typedef struct packed {
        logic        co;
        logic [47:0] p;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_c = 1'b0, rst_opmode = 1'b0, rst_carryin = 1'b0, rst_p = 1'b0;
    logic ce_c = 1'b1, ce_opmode = 1'b1, ce_carryin = 1'b1, ce_p = 1'b1;
    logic [7:0]  opmode = '0;
    logic [35:0] m = '0;
    logic [47:0] dab = '0, c = '0, pcin = '0;
    logic        carryin = 1'b0;
    logic [47:0] p, pcout;
    logic        carryout, carryoutf;

    logic [7:0]  opmode_cb = '0;
    logic [35:0] m_cb = '0;
    logic [47:0] dab_cb = '0, c_cb = '0, pcin_cb = '0;
    logic        carryin_cb = 1'b0;
    logic [47:0] p_cb, pcout_cb, p_ci, pcout_ci;
    logic        co_cb, cof_cb, co_ci, cof_ci;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t model = '0;

    post_add_acc dut (
        .clk(clk), .rst_c(rst_c), .rst_opmode(rst_opmode), .rst_carryin(rst_carryin), .rst_p(rst_p),
        .ce_c(ce_c), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin), .ce_p(ce_p),
        .opmode(opmode), .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
        .p(p), .pcout(pcout), .carryout(carryout), .carryoutf(carryoutf)
    );

    post_add_acc #(.CREG(0), .OPMODEREG(0), .CARRYINREG(0), .PREG(0), .CARRYOUTREG(0)) dut_cb (
        .clk(clk), .rst_c(rst_c), .rst_opmode(rst_opmode), .rst_carryin(rst_carryin), .rst_p(rst_p),
        .ce_c(ce_c), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin), .ce_p(ce_p),
        .opmode(opmode_cb), .m(m_cb), .dab(dab_cb), .c(c_cb), .pcin(pcin_cb), .carryin(carryin_cb),
        .p(p_cb), .pcout(pcout_cb), .carryout(co_cb), .carryoutf(cof_cb)
    );

    post_add_acc #(.CREG(0), .OPMODEREG(0), .CARRYINREG(0), .PREG(0), .CARRYOUTREG(0),
                   .CARRYINSEL("CARRYIN")) dut_ci (
        .clk(clk), .rst_c(rst_c), .rst_opmode(rst_opmode), .rst_carryin(rst_carryin), .rst_p(rst_p),
        .ce_c(ce_c), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin), .ce_p(ce_p),
        .opmode(opmode_cb), .m(m_cb), .dab(dab_cb), .c(c_cb), .pcin(pcin_cb), .carryin(carryin_cb),
        .p(p_ci), .pcout(pcout_ci), .carryout(co_ci), .carryoutf(cof_ci)
    );

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Reference arithmetic in 64-bit integers; bit 48 is the carry/borrow.
    function automatic exp_t alu(input logic [7:0] op, input logic [35:0] mv, input logic [47:0] dabv,
                                 input logic [47:0] cv, input logic [47:0] pcinv, input logic [47:0] pv,
                                 input logic cinv);
        longint unsigned xv, zv, r;
        case (op[1:0])
            2'd0: xv = 0;
            2'd1: xv = longint'(mv);
            2'd2: xv = longint'(pv);
            default: xv = longint'(dabv);
        endcase
        case (op[3:2])
            2'd0: zv = 0;
            2'd1: zv = longint'(pcinv);
            2'd2: zv = longint'(pv);
            default: zv = longint'(cv);
        endcase
        r = op[7] ? zv - (xv + longint'(cinv)) : zv + xv + longint'(cinv);
        return exp_t'(r[48:0]);
    endfunction

    task automatic pop_compare(input string tag, input logic [47:0] pv, input logic [47:0] pcv,
                               input logic cov, input logic cofv);
        exp_t e;
        check({tag, " sb_depth"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " p"}, 64'(pv), 64'(e.p));
            check({tag, " pcout"}, 64'(pcv), 64'(e.p));
            check({tag, " carryout"}, 64'(cov), 64'(e.co));
            check({tag, " carryoutf"}, 64'(cofv), 64'(e.co));
        end
    endtask

    // Let registered operands and the two-stage carry-in settle while P holds.
    task automatic fill();
        ce_p = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic step(input int n, input logic ce, input string tag);
        for (int i = 0; i < n; i++) begin
            ce_p = ce;
            if (rst_p)
                model = '0;
            else if (ce)
                model = alu(opmode, m, dab, c, pcin, model.p, opmode[5]);
            sb.push_back(model);
            @(posedge clk);
            #1;
            pop_compare(tag, p, pcout, carryout, carryoutf);
        end
    endtask

    task automatic comb_case(input logic [7:0] op, input logic [47:0] cv, input logic [35:0] mv,
                             input logic [47:0] dabv, input logic [47:0] pcinv, input logic cin_port,
                             input string tag);
        opmode_cb = op; c_cb = cv; m_cb = mv; dab_cb = dabv; pcin_cb = pcinv; carryin_cb = cin_port;
        sb.push_back(alu(op, mv, dabv, cv, pcinv, 48'd0, op[5]));
        sb.push_back(alu(op, mv, dabv, cv, pcinv, 48'd0, cin_port));
        #1;
        pop_compare({tag, " op5"}, p_cb, pcout_cb, co_cb, cof_cb);
        pop_compare({tag, " cinport"}, p_ci, pcout_ci, co_ci, cof_ci);
    endtask

    initial begin
        #2;
        {rst_c, rst_opmode, rst_carryin, rst_p} = 4'hF;
        repeat (2) @(posedge clk);
        #3;
        {rst_c, rst_opmode, rst_carryin, rst_p} = 4'h0;
        check("reset p", 64'(p), 64'd0);
        check("reset carryout", 64'(carryout), 64'd0);
        check("reset pcout", 64'(pcout), 64'd0);
        model = '0;

        // Product through X, nothing on Z.
        opmode = 8'h01; m = 36'd6;
        fill(); step(1, 1'b1, "t1_m");

        // Accumulate from zero, then hold with ce_p low.
        rst_p = 1'b1; #1; rst_p = 1'b0; model = '0;
        opmode = 8'h09; m = 36'd5;
        fill(); step(4, 1'b1, "t2_acc"); step(2, 1'b0, "t2_hold");

        // C minus (M + carry), without and with borrow.
        opmode = 8'hAD; c = 48'd100; m = 36'd30;
        fill(); step(1, 1'b1, "t3_sub");
        c = 48'd10;
        fill(); step(1, 1'b1, "t3_borrow");

        // PCIN all ones plus carry-in wraps to zero.
        opmode = 8'h24; pcin = 48'hFFFF_FFFF_FFFF;
        fill(); step(1, 1'b1, "t4_wrap");

        opmode = 8'h87; pcin = 48'h0000_0000_1000; dab = 48'h0000_0000_0FFF;
        fill(); step(1, 1'b1, "t4_dab");

        for (int i = 0; i < 8; i++) begin
            opmode = 8'($urandom);
            m = {4'($urandom), 32'($urandom)};
            dab = {16'($urandom), 32'($urandom)};
            c = {16'($urandom), 32'($urandom)};
            pcin = {16'($urandom), 32'($urandom)};
            fill(); step(1, 1'b1, "rand");
        end

        // Reset mid-accumulate acts at once and restarts accumulation from 0.
        rst_p = 1'b1; #1; rst_p = 1'b0; model = '0;
        opmode = 8'h09; m = 36'd5;
        fill(); step(2, 1'b1, "t5_pre");
        @(negedge clk);
        rst_p = 1'b1;
        #1;
        check("t5_async p", 64'(p), 64'd0);
        check("t5_async carryout", 64'(carryout), 64'd0);
        model = '0;
        step(2, 1'b1, "t5_held");
        step(1, 1'b0, "t5_held_ce0");
        rst_p = 1'b0;
        step(2, 1'b1, "t5_restart");

        // Fully combinational instances follow live inputs.
        comb_case(8'h0D, 48'd100, 36'd7, 48'd0, 48'd0, 1'b1, "t6_add");
        comb_case(8'h2D, 48'd100, 36'd7, 48'd0, 48'd0, 1'b0, "t6_op5");
        comb_case(8'hAD, 48'd10, 36'd30, 48'd0, 48'd0, 1'b1, "t6_sub");
        comb_case(8'h07, 48'd0, 36'd0, 48'h1234_5678_9ABC, 48'd1, 1'b1, "t6_dab");
        comb_case(8'h04, 48'd0, 36'd0, 48'd0, 48'hFFFF_FFFF_FFFF, 1'b1, "t6_wrap");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
